// File: rtl/adbg_crc_pkg.sv
// Shared constants and types for the debug CRC-32 sequencer and its serial engine.
// The engine works on the bit-reflected polynomial, so data and CRC travel LSB first.
package adbg_crc_pkg;

   localparam int CRC_W        = 32;
   localparam int CRC_CNT_LAST = 31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_CHECK = 1'b0;
   localparam logic MODE_GEN   = 1'b1;

   localparam logic [CRC_W-1:0] CRC_POLY = 32'hEDB88320;
   localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/adbg_crc32.sv
// Bit-serial reflected CRC-32 engine: clear to all ones, update one data bit per enable,
// or shift the register right one place per shift so crc[0] appears on serial_out.
module adbg_crc32
   import adbg_crc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             enable,
   input  logic             shift,
   input  logic             data,
   output logic [CRC_W-1:0] crc_out,
   output logic             serial_out
);

   logic [CRC_W-1:0] crc_reg;
   logic [CRC_W-1:0] crc_upd;
   logic             feedback;

   assign feedback = crc_reg[0] ^ data;

   genvar gi;
   generate
      for (gi = 0; gi < CRC_W; gi++) begin : g_upd
         if (gi == CRC_W - 1) begin : g_top
            assign crc_upd[gi] = feedback & CRC_POLY[gi];
         end else begin : g_low
            assign crc_upd[gi] = crc_reg[gi+1] ^ (feedback & CRC_POLY[gi]);
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_reg <= CRC_INIT;
      end else if (clr) begin
         crc_reg <= CRC_INIT;
      end else if (enable) begin
         crc_reg <= crc_upd;
      end else if (shift) begin
         crc_reg <= {1'b0, crc_reg[CRC_W-1:1]};
      end
   end

   assign crc_out    = crc_reg;
   assign serial_out = crc_reg[0];

endmodule

// File: rtl/adbg_crc_seq.sv
// Burst sequencer for the serial CRC-32 engine: feeds data bits, then either checks the
// received CRC (write burst) or streams the computed CRC out (read burst).
module adbg_crc_seq
   import adbg_crc_pkg::*;
#(
   parameter int LEN_W = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             abort_i,
   input  logic             bit_valid_i,
   input  logic             bit_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             crc_ok_o,
   output logic             crc_err_o,
   output logic             crc_bit_o,
   output logic             crc_bit_valid_o,
   output logic             crc_clr_o,
   output logic             crc_en_o,
   output logic             crc_shift_o,
   output logic             crc_data_o,
   input  logic             crc_serial_i
);

   localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'(CRC_CNT_LAST);

   state_t           state_reg, state_next;
   logic [LEN_W-1:0] cnt_reg,   cnt_next;
   logic [LEN_W-1:0] len_reg,   len_next;
   logic             mode_reg,  mode_next;
   logic             err_reg,   err_next;
   logic             ok_reg,    ok_next;
   logic             bad_reg,   bad_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         len_reg   <= '0;
         mode_reg  <= MODE_CHECK;
         err_reg   <= 1'b0;
         ok_reg    <= 1'b0;
         bad_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
         mode_reg  <= mode_next;
         err_reg   <= err_next;
         ok_reg    <= ok_next;
         bad_reg   <= bad_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      len_next        = len_reg;
      mode_next       = mode_reg;
      err_next        = err_reg;
      ok_next         = ok_reg;
      bad_next        = bad_reg;
      busy_o          = 1'b0;
      done_o          = 1'b0;
      crc_bit_o       = 1'b0;
      crc_bit_valid_o = 1'b0;
      crc_clr_o       = 1'b0;
      crc_en_o        = 1'b0;
      crc_shift_o     = 1'b0;
      crc_data_o      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_i && !abort_i) begin
               crc_clr_o  = 1'b1;
               ok_next    = 1'b0;
               bad_next   = 1'b0;
               err_next   = 1'b0;
               cnt_next   = '0;
               mode_next  = mode_i;
               len_next   = len_i;
               state_next = (len_i != '0) ? DATA : CRC;
            end
         end

         DATA: begin
            busy_o     = 1'b1;
            crc_data_o = bit_i;
            if (abort_i) begin
               state_next = IDLE;
               cnt_next   = '0;
               err_next   = 1'b0;
               ok_next    = 1'b0;
               bad_next   = 1'b0;
            end else if (bit_valid_i) begin
               crc_en_o = 1'b1;
               if (cnt_reg == len_reg - 1'b1) begin
                  cnt_next   = '0;
                  state_next = CRC;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end

         CRC: begin
            busy_o = 1'b1;
            if (mode_reg == MODE_GEN) begin
               crc_bit_o = crc_serial_i;
            end
            if (abort_i) begin
               state_next = IDLE;
               cnt_next   = '0;
               err_next   = 1'b0;
               ok_next    = 1'b0;
               bad_next   = 1'b0;
            end else if (bit_valid_i) begin
               crc_shift_o     = 1'b1;
               crc_bit_valid_o = (mode_reg == MODE_GEN);
               if (mode_reg == MODE_CHECK && (bit_i != crc_serial_i)) begin
                  err_next = 1'b1;
               end
               if (cnt_reg == CNT_LAST) begin
                  // Verdict is latched on the last bit so it is already valid during done_o.
                  cnt_next   = '0;
                  state_next = DONE;
                  ok_next    = (mode_reg == MODE_CHECK) && !err_next;
                  bad_next   = (mode_reg == MODE_CHECK) && err_next;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end

         DONE: begin
            state_next = IDLE;
            if (abort_i) begin
               cnt_next = '0;
               err_next = 1'b0;
               ok_next  = 1'b0;
               bad_next = 1'b0;
            end else begin
               done_o = 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign crc_ok_o  = ok_reg;
   assign crc_err_o = bad_reg;

endmodule

// File: tb/tb_adbg_crc_seq.sv
// Directed bench for the CRC burst sequencer driving a real serial CRC-32 engine.
// Single-cycle behaviour comes from a vector table; full bursts use a burst task.
module tb_adbg_crc_seq;
   import adbg_crc_pkg::*;

   localparam int          LEN_W   = 16;
   localparam logic [31:0] CRC_REF = 32'h340BC6D9;
   localparam logic [71:0] MSG     = "123456789";

   logic             clk;
   logic             rst_n;
   logic             start_i, mode_i, abort_i, bit_valid_i, bit_i;
   logic [LEN_W-1:0] len_i;
   logic             busy_o, done_o, crc_ok_o, crc_err_o, crc_bit_o, crc_bit_valid_o;
   logic             crc_clr_o, crc_en_o, crc_shift_o, crc_data_o, crc_serial_i;
   logic [31:0]      crc_word;

   int n_checks = 0;
   int n_fail   = 0;

   adbg_crc_seq #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .len_i(len_i),
      .abort_i(abort_i), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
      .busy_o(busy_o), .done_o(done_o), .crc_ok_o(crc_ok_o), .crc_err_o(crc_err_o),
      .crc_bit_o(crc_bit_o), .crc_bit_valid_o(crc_bit_valid_o), .crc_clr_o(crc_clr_o),
      .crc_en_o(crc_en_o), .crc_shift_o(crc_shift_o), .crc_data_o(crc_data_o),
      .crc_serial_i(crc_serial_i)
   );

   adbg_crc32 u_eng (
      .clk(clk), .rst(~rst_n), .clr(crc_clr_o), .enable(crc_en_o), .shift(crc_shift_o),
      .data(crc_data_o), .crc_out(crc_word), .serial_out(crc_serial_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic             start;
      logic             mode;
      logic [LEN_W-1:0] len;
      logic             abort;
      logic             valid;
      logic             bitv;
      logic [8:0]       exp;   // {busy, done, clr, en, shift, bit_valid, crc_bit, ok, err}
   } vec_t;

   vec_t tbl[12];
   bit   pat[4];

   function automatic logic data_bit(input int k);
      logic [71:0] m;
      m = MSG;
      return m[(8 - k / 8) * 8 + (k % 8)];
   endfunction

   function automatic logic [8:0] out_vec();
      return {busy_o, done_o, crc_clr_o, crc_en_o, crc_shift_o, crc_bit_valid_o,
              crc_bit_o, crc_ok_o, crc_err_o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input string name, input logic mode, input int len,
                            input logic [31:0] crc_in, input bit gaps, input bit poke,
                            output logic [31:0] gen_crc, output int n_en, output int n_shift,
                            output int n_done, output int n_valid, output logic ok,
                            output logic err, output logic ok_late);
      int   k, j, post, nbv;
      bit   fin;
      logic clr_seen;
      gen_crc = '0; n_en = 0; n_shift = 0; n_done = 0; n_valid = 0;
      ok = 1'b0; err = 1'b0; ok_late = 1'b0;
      k = 0; j = 0; post = 0; nbv = 0; fin = 0;
      start_i = 1'b1; mode_i = mode; len_i = len[LEN_W-1:0];
      abort_i = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0;
      @(negedge clk);
      clr_seen = crc_clr_o;
      tick();
      start_i = 1'b0; mode_i = 1'b0; len_i = '0;
      check({name, " clr"}, 32'(clr_seen), 32'd1);
      for (int cyc = 0; cyc < 2000 && post < 3; cyc++) begin
         start_i = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0;
         if (k < len || j < 32) begin
            bit_valid_i = gaps ? (cyc < 4 ? pat[cyc] : 1'($urandom_range(0, 1))) : 1'b1;
            bit_i = (k < len) ? data_bit(k) : (mode ? 1'b0 : crc_in[j]);
         end
         if (poke && cyc == 5) begin
            start_i = 1'b1; len_i = 16'd3; mode_i = ~mode;
         end
         @(negedge clk);
         if (crc_en_o) n_en++;
         if (crc_shift_o) n_shift++;
         if (crc_bit_valid_o && nbv < 32) begin
            gen_crc[nbv] = crc_bit_o;
            nbv++;
         end
         if (done_o) begin
            n_done++;
            ok = crc_ok_o;
            err = crc_err_o;
            fin = 1;
         end
         if (post == 2) ok_late = crc_ok_o;
         if (bit_valid_i) begin
            n_valid++;
            if (k < len) k++;
            else j++;
         end
         if (fin) post++;
         tick();
      end
      check({name, " done_seen"}, 32'(fin), 32'd1);
      check({name, " idle_after"}, 32'(busy_o), 32'd0);
      $display("burst %s mode=%0d len=%0d crc=0x%08h en=%0d shift=%0d valid=%0d done=%0d ok=%0d err=%0d",
               name, mode, len, gen_crc, n_en, n_shift, n_valid, n_done, ok, err);
   endtask

   logic [31:0] g_crc;
   int          g_en, g_sh, g_dn, g_vl;
   logic        g_ok, g_err, g_okl;

   initial begin
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      tbl[0]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 9'b000_000_000};
      tbl[1]  = '{1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 9'b000_000_000};
      tbl[2]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 9'b000_000_000};
      tbl[3]  = '{1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 9'b001_000_000};
      tbl[4]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 9'b100_011_100};
      tbl[5]  = '{1'b1, 1'b0, 16'd5, 1'b0, 1'b0, 1'b0, 9'b100_000_100};
      tbl[6]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 9'b100_000_100};
      tbl[7]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 9'b000_000_000};
      tbl[8]  = '{1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 9'b001_000_000};
      tbl[9]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 9'b100_100_000};
      tbl[10] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 9'b100_000_000};
      tbl[11] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 9'b000_000_000};

      rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; len_i = '0;
      abort_i = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0;
      repeat (2) @(negedge clk);
      check("reset outputs", 32'(out_vec()), 32'd0);
      check("reset engine", crc_word, 32'hFFFF_FFFF);
      rst_n = 1'b1;
      tick();

      for (int r = 0; r < 12; r++) begin
         start_i = tbl[r].start; mode_i = tbl[r].mode; len_i = tbl[r].len;
         abort_i = tbl[r].abort; bit_valid_i = tbl[r].valid; bit_i = tbl[r].bitv;
         @(negedge clk);
         $display("vector %0d outputs=%09b expected=%09b", r, out_vec(), tbl[r].exp);
         check($sformatf("vector %0d", r), 32'(out_vec()), 32'(tbl[r].exp));
         tick();
      end
      start_i = 1'b0; abort_i = 1'b0; bit_valid_i = 1'b0; len_i = '0;
      tick();

      // Generate, 72 bits of "123456789"
      run_burst("gen72", MODE_GEN, 72, 32'h0, 1'b0, 1'b0, g_crc, g_en, g_sh, g_dn, g_vl, g_ok, g_err, g_okl);
      check("gen72 crc", g_crc, CRC_REF);
      check("gen72 done count", 32'(g_dn), 32'd1);
      check("gen72 ok/err", {30'd0, g_ok, g_err}, 32'd0);

      run_burst("chk72", MODE_CHECK, 72, CRC_REF, 1'b0, 1'b0, g_crc, g_en, g_sh, g_dn, g_vl, g_ok, g_err, g_okl);
      check("chk72 ok/err", {30'd0, g_ok, g_err}, 32'd2);
      check("chk72 ok held", 32'(g_okl), 32'd1);

      run_burst("chk72bad", MODE_CHECK, 72, CRC_REF ^ 32'h20, 1'b0, 1'b0, g_crc, g_en, g_sh, g_dn, g_vl, g_ok, g_err, g_okl);
      check("chk72bad ok/err", {30'd0, g_ok, g_err}, 32'd1);

      run_burst("chk0", MODE_CHECK, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, g_crc, g_en, g_sh, g_dn, g_vl, g_ok, g_err, g_okl);
      check("chk0 ok/err", {30'd0, g_ok, g_err}, 32'd2);
      check("chk0 valid bits", 32'(g_vl), 32'd32);
      check("chk0 en count", 32'(g_en), 32'd0);

      run_burst("gen72gaps", MODE_GEN, 72, 32'h0, 1'b1, 1'b0, g_crc, g_en, g_sh, g_dn, g_vl, g_ok, g_err, g_okl);
      check("gaps crc", g_crc, CRC_REF);
      check("gaps en count", 32'(g_en), 32'd72);
      check("gaps shift count", 32'(g_sh), 32'd32);

      // Abort on data bit 40
      start_i = 1'b1; mode_i = MODE_GEN; len_i = 16'd72;
      tick();
      start_i = 1'b0;
      for (int k = 0; k < 40; k++) begin
         bit_valid_i = 1'b1; bit_i = data_bit(k);
         tick();
      end
      bit_valid_i = 1'b1; bit_i = data_bit(40); abort_i = 1'b1;
      @(negedge clk);
      check("abort en/done", {30'd0, crc_en_o, done_o}, 32'd0);
      tick();
      abort_i = 1'b0; bit_valid_i = 1'b0;
      @(negedge clk);
      check("abort busy/done", {30'd0, busy_o, done_o}, 32'd0);
      tick();
      $display("burst abort mode=1 len=72 aborted at bit 40");
      run_burst("after_abort", MODE_GEN, 72, 32'h0, 1'b0, 1'b0, g_crc, g_en, g_sh, g_dn, g_vl, g_ok, g_err, g_okl);
      check("after_abort crc", g_crc, CRC_REF);

      // Start while busy is ignored
      run_burst("poke", MODE_GEN, 72, 32'h0, 1'b0, 1'b1, g_crc, g_en, g_sh, g_dn, g_vl, g_ok, g_err, g_okl);
      check("poke crc", g_crc, CRC_REF);
      check("poke en count", 32'(g_en), 32'd72);

      // Asynchronous reset in the middle of the CRC phase
      start_i = 1'b1; mode_i = MODE_GEN; len_i = 16'd0;
      tick();
      start_i = 1'b0; bit_valid_i = 1'b1; bit_i = 1'b0;
      repeat (10) tick();
      check("pre-reset busy", 32'(busy_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset outputs", 32'(out_vec()), 32'd0);
      check("async reset engine", crc_word, 32'hFFFF_FFFF);
      bit_valid_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      $display("burst reset mode=1 len=0 reset mid-CRC");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
